// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 interrupt controller: register numbers,
// handler address, SR/Cause field positions and the FSM state type.
package cp0_pkg;

    localparam logic [4:0]  CP0_SR       = 5'd12;
    localparam logic [4:0]  CP0_CAUSE    = 5'd13;
    localparam logic [4:0]  CP0_EPC      = 5'd14;
    localparam logic [4:0]  CP0_PRID     = 5'd15;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

    localparam int SR_IM_HI    = 15;
    localparam int SR_IM_LO    = 10;
    localparam int SR_EXL      = 1;
    localparam int SR_IE       = 0;
    localparam int CAUSE_IP_HI = 15;
    localparam int CAUSE_IP_LO = 10;

    localparam int NUM_HWINT   = 6;

    // The FSM state is the SR.EXL flop itself.
    typedef enum logic {
        RUN = 1'b0,
        ISR = 1'b1
    } cp0_state_t;

endpackage

// File: rtl/cp0_int_ctrl_if.sv
// Bus between the datapath (master) and the CP0 interrupt controller (slave).
interface cp0_int_ctrl_if;

    logic [31:0] cpc;
    logic [5:0]  hwint;
    logic [4:0]  sel;
    logic [31:0] din;
    logic        we;
    logic        eret;
    logic [31:0] dout;
    logic        npc4180;
    logic        if_eret;
    logic [31:0] epc;

    modport master (
        output cpc, hwint, sel, din, we, eret,
        input  dout, npc4180, if_eret, epc
    );

    modport slave (
        input  cpc, hwint, sel, din, we, eret,
        output dout, npc4180, if_eret, epc
    );

endinterface

// File: rtl/cp0_int_ctrl_int_sync.sv
// Multi-flop synchronizer for the asynchronous hardware interrupt lines.
module int_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;

    // Shift the raw levels through SYNC_STAGES flops; stage 0 may go metastable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            // NOTE: non-blocking so every stage samples its predecessor's old value.
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt controller: SR/Cause/EPC/PRId, take/return decision and
// mfc0/mtc0 access for the single-cycle MIPS core.
module cp0_int_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID        = 32'h0000_0001,
    parameter int          SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           reset,
    cp0_int_ctrl_if.slave  bus
);

    cp0_state_t  r_state;
    logic        r_ie;
    logic [5:0]  r_im;
    logic [31:0] r_epc;

    cp0_state_t  w_state_next;
    logic        w_ie_next;
    logic [5:0]  w_im_next;
    logic [31:0] w_epc_next;

    logic [5:0]  w_ip;
    logic        w_pend;
    logic        w_take;
    logic        w_ret;
    logic [31:0] w_sr;
    logic [31:0] w_cause;

    int_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .WIDTH       (NUM_HWINT)
    ) u_int_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (bus.hwint),
        .o_sync  (w_ip)
    );

    // Take/return strobes depend only on flops and eret, never on raw hwint.
    assign w_pend = (|(w_ip & r_im)) & r_ie & (r_state == RUN);
    assign w_take = w_pend;
    assign w_ret  = bus.eret & (r_state == ISR) & ~w_take;

    assign bus.npc4180 = w_take;
    assign bus.if_eret = w_ret;
    assign bus.epc     = r_epc;

    // State register together with the SR fields and EPC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
            r_ie    <= 1'b0;
            r_im    <= '0;
            r_epc   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ie    <= w_ie_next;
            r_im    <= w_im_next;
            r_epc   <= w_epc_next;
        end
    end

    // Next-state: take beats eret, which beats an mtc0 in the same cycle.
    always_comb begin
        // NOTE: every output defaults to its held value first, so no latch is inferred.
        w_state_next = r_state;
        w_ie_next    = r_ie;
        w_im_next    = r_im;
        w_epc_next   = r_epc;
        if (w_take) begin
            w_state_next = ISR;
            w_epc_next   = {bus.cpc[31:2], 2'b00};
        end else if (w_ret) begin
            w_state_next = RUN;
        end else if (bus.we) begin
            if (bus.sel == CP0_SR) begin
                w_im_next    = bus.din[SR_IM_HI:SR_IM_LO];
                w_state_next = cp0_state_t'(bus.din[SR_EXL]);
                w_ie_next    = bus.din[SR_IE];
            end else if (bus.sel == CP0_EPC) begin
                w_epc_next = bus.din;
            end
        end
    end

    // mfc0 read mux; unimplemented bits and registers read as zero.
    always_comb begin
        w_sr                        = '0;
        w_sr[SR_IM_HI:SR_IM_LO]     = r_im;
        w_sr[SR_EXL]                = (r_state == ISR);
        w_sr[SR_IE]                 = r_ie;
        w_cause                     = '0;
        w_cause[CAUSE_IP_HI:CAUSE_IP_LO] = w_ip;
        case (bus.sel)
            CP0_SR:    bus.dout = w_sr;
            CP0_CAUSE: bus.dout = w_cause;
            CP0_EPC:   bus.dout = r_epc;
            CP0_PRID:  bus.dout = PRID;
            default:   bus.dout = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_cp0_int_ctrl;

    localparam logic [31:0] PRID = 32'h0000_0001;
    localparam int          SYNC = 2;

    logic clk;
    logic reset;

    cp0_int_ctrl_if bus ();

    cp0_int_ctrl #(
        .PRID        (PRID),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit        m_exl = 0;
    bit        m_ie  = 0;
    bit [5:0]  m_im  = 0;
    bit [31:0] m_epc = 0;
    bit [5:0]  hq[$];            // hwint samples taken at each edge since reset

    function automatic bit [5:0] m_ip();
        if (hq.size() >= SYNC) return hq[hq.size() - SYNC];
        return 6'd0;
    endfunction

    function automatic bit m_pend();
        return ((m_ip() & m_im) != 0) && m_ie && !m_exl;
    endfunction

    function automatic bit [31:0] m_dout(input bit [4:0] s);
        case (s)
            5'd12:   return (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
            5'd13:   return 32'(m_ip()) << 10;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_exl = 0; m_ie = 0; m_im = 0; m_epc = 0;
            hq.delete();
        end else begin
            if (m_pend()) begin
                m_exl = 1;
                m_epc = bus.cpc & 32'hFFFF_FFFC;
            end else if (bus.eret && m_exl) begin
                m_exl = 0;
            end else if (bus.we && bus.sel == 5'd12) begin
                m_im  = bus.din[15:10];
                m_exl = bus.din[1];
                m_ie  = bus.din[0];
            end else if (bus.we && bus.sel == 5'd14) begin
                m_epc = bus.din;
            end
            hq.push_back(bus.hwint);
            if (hq.size() > SYNC) void'(hq.pop_front());
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        check("npc4180", 32'(bus.npc4180), 32'(m_pend()));
        check("if_eret", 32'(bus.if_eret), 32'(bus.eret && m_exl && !m_pend()));
        check("epc",     bus.epc,          m_epc);
        check("dout",    bus.dout,         m_dout(bus.sel));
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input string name, input logic [4:0] s, input logic [31:0] exp);
        bus.sel = s;
        #1;
        check(name, bus.dout, exp);
    endtask

    task automatic mtc0(input logic [4:0] s, input logic [31:0] d);
        bus.sel = s; bus.din = d; bus.we = 1'b1;
        tick();
        bus.we = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        bus.cpc   = 32'h0000_3000;
        bus.hwint = 6'h3F;
        bus.sel   = 5'd0;
        bus.din   = 32'd0;
        bus.we    = 1'b0;
        bus.eret  = 1'b0;

        // Reset held 3 cycles with all lines asserted.
        tick(3);
        check("rst_npc",   32'(bus.npc4180), 32'd0);
        check("rst_ieret", 32'(bus.if_eret), 32'd0);
        reset = 1'b0;
        tick(3);
        check("idle_npc", 32'(bus.npc4180), 32'd0);
        rd("rst_sr",   5'd12, 32'h0);
        rd("rst_epc",  5'd14, 32'h0);
        rd("rst_prid", 5'd15, 32'h0000_0001);
        rd("cause_all", 5'd13, 32'h0000_FC00);
        bus.hwint = 6'h00;
        tick(3);

        // Enabled take.
        mtc0(5'd12, 32'h0000_0401);
        bus.hwint = 6'h01;
        bus.cpc   = 32'h0000_3010;
        tick();
        check("pre_take", 32'(bus.npc4180), 32'd0);
        tick();
        check("take", 32'(bus.npc4180), 32'd1);
        tick();
        check("take_once", 32'(bus.npc4180), 32'd0);
        check("take_epc",  bus.epc, 32'h0000_3010);
        rd("take_sr",    5'd12, 32'h0000_0403);
        rd("take_cause", 5'd13, 32'h0000_0400);

        // Return path with software-written EPC.
        bus.hwint = 6'h00;
        mtc0(5'd14, 32'h0000_3020);
        tick(2);
        bus.eret = 1'b1;
        #1;
        check("ret_ieret", 32'(bus.if_eret), 32'd1);
        check("ret_epc",   bus.epc, 32'h0000_3020);
        tick();
        rd("ret_sr", 5'd12, 32'h0000_0401);
        check("eret_run", 32'(bus.if_eret), 32'd0);
        bus.eret = 1'b0;
        tick();

        // Masked line, then an enabled one; mtc0 SR in the take cycle is dropped.
        mtc0(5'd12, 32'h0000_0801);
        bus.hwint = 6'h01;
        tick(3);
        rd("mask_cause", 5'd13, 32'h0000_0400);
        check("mask_npc", 32'(bus.npc4180), 32'd0);
        bus.hwint = 6'h02;
        bus.cpc   = 32'h0000_3102;
        tick(2);
        check("take2", 32'(bus.npc4180), 32'd1);
        bus.sel = 5'd12; bus.din = 32'd0; bus.we = 1'b1;
        tick();
        bus.we = 1'b0;
        rd("drop_sr",  5'd12, 32'h0000_0803);
        check("take2_epc", bus.epc, 32'h0000_3100);

        // Interrupt still held across eret: immediate re-take.
        bus.eret = 1'b1;
        #1;
        check("held_ieret", 32'(bus.if_eret), 32'd1);
        tick();
        bus.eret = 1'b0;
        bus.cpc  = 32'h0000_3200;
        #1;
        check("retake", 32'(bus.npc4180), 32'd1);
        tick();
        check("retake_epc", bus.epc, 32'h0000_3200);

        // Asynchronous reset while in the handler.
        #2;
        reset = 1'b1;
        #1;
        rd("mid_rst_sr", 5'd12, 32'h0);
        check("mid_rst_epc", bus.epc, 32'h0);
        tick();
        reset     = 1'b0;
        bus.hwint = 6'h00;
        bus.eret  = 1'b1;
        #1;
        check("post_rst_eret", 32'(bus.if_eret), 32'd0);
        tick();
        bus.eret = 1'b0;

        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) bus.hwint = 6'($urandom);
            bus.cpc  = $urandom;
            bus.sel  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
            bus.din  = $urandom;
            if ($urandom_range(0, 1) == 0) bus.din[0] = 1'b1;
            bus.we   = ($urandom_range(0, 5) == 0);
            bus.eret = ($urandom_range(0, 4) == 0);
            reset    = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cp0_int_ctrl.md
# cp0_int_ctrl

Coprocessor-0 interrupt controller for the single-cycle MIPS microsystem. It holds the SR, Cause, EPC and PRId registers and synchronizes six external hardware interrupt lines. It decides the cycle in which the CPU is redirected to the handler at 0x0000_4180, and produces the `npc4180`, `if_eret` and `epc` controls that the next-PC logic consumes. It also serves `mfc0`/`mtc0` accesses from the datapath.

## Interface
- `PRID`, default 32'h0000_0001: read-only value returned for register 15.
- `SYNC_STAGES`, default 2: flop depth of the HWInt synchronizer; legal values are 2 and 3.
- `clk`, input, 1: rising-edge system clock.
- `reset`, input, 1: one clock; reset is asynchronous and active-high.
- `cpc`, input, 32: PC of the instruction executing this cycle.
- `hwint`, input, 6: asynchronous device interrupt levels, active-high.
- `sel`, input, 5: CP0 register number for `mfc0`/`mtc0`.
- `din`, input, 32: `mtc0` write data (GPR rt).
- `we`, input, 1: `mtc0` executing this cycle.
- `eret`, input, 1: `eret` decoded this cycle.
- `dout`, output, 32: `mfc0` read data, combinational on `sel`.
- `npc4180`, output, 1: take-interrupt strobe; also squashes the current instruction's GPR/DM writes.
- `if_eret`, output, 1: return strobe; the next PC selects `epc`.
- `epc`, output, 32: current EPC register value.

## Operation
- SR (reg 12): IM = [15:10], EXL = [1], IE = [0]. All other bits read 0 and ignore writes.
- Cause (reg 13): IP = [15:10] is the synchronized `hwint`, refreshed every cycle. Cause is read-only, and all other bits read 0.
- EPC (reg 14): read/write through `mtc0`, and loaded by hardware on a take.
- PRId (reg 15): returns `PRID`.
- Any other `sel` value: `dout` = 0 and writes are dropped.
- FSM states:
  - RUN: EXL = 0, interrupts eligible.
  - ISR: EXL = 1, handler executing, further interrupts blocked.
- Pending: `pend` = |(IP & IM) & IE & ~EXL.
- RUN -> ISR when `pend` = 1:
  - `npc4180` = 1 combinationally in that cycle.
  - At the edge: EPC <= {`cpc`[31:2], 2'b00} and EXL <= 1.
  - The instruction at `cpc` is squashed and re-executed after return.
- ISR -> RUN on `eret` = 1:
  - `if_eret` = 1 combinationally.
  - At the edge: EXL <= 0.
- `eret` in RUN is a no-op: `if_eret` = 0 and no state change.
- Writing SR.EXL through `mtc0` moves the FSM, because state and EXL are the same flop.
- Simultaneous-event priority:
  - Take beats `mtc0` in the same cycle: the write is dropped because the instruction is squashed.
  - Take beats `eret` (this only occurs if EXL = 0, so `eret` is already a no-op).
  - `npc4180` and `if_eret` are never both 1.
- `mtc0` to EPC during ISR followed by `eret`: `if_eret` returns to the written value.
- `epc` is driven from the register. `mtc0` EPC and `eret` cannot coincide, since they are one instruction each.

## Timing
- Reset values:
  - SR = 0, EPC = 0, synchronizer flops = 0, state RUN.
  - `npc4180` = 0, `if_eret` = 0, `epc` = 0.
  - `dout` = 0 for `sel` 12–14.
- Interrupt latency: `hwint` high before edge k becomes visible in IP after edge k + `SYNC_STAGES` − 1. `npc4180` is asserted in the following cycle if enabled.
- `mtc0` takes effect at the write edge. An IE/IM write affects `pend` in the next cycle.
- Back-to-back interrupts: after `eret`, `pend` may assert in the very next cycle. EPC is then reloaded with the return target.
- `hwint` deasserting before the take cancels the take (level-sensitive, no latching).
- `reset` mid-ISR forces RUN and EXL = 0 immediately, asynchronously.
- Outputs `npc4180` and `if_eret` are combinational from flops and `eret` only. They have no path from `hwint`.

## Structure
- Package `cp0_pkg`:
  - Register numbers CP0_SR = 12, CP0_CAUSE = 13, CP0_EPC = 14, CP0_PRID = 15.
  - HANDLER_ADDR = 32'h0000_4180.
  - SR/Cause bit positions (IM/IP high/low, EXL, IE).
  - State encoding RUN = 1'b0, ISR = 1'b1.
- One sub-module: `int_sync`, a 6-bit multi-flop synchronizer parameterized by `SYNC_STAGES` and reset to 0.

## Test plan
- Reset check: assert `reset` for 3 cycles, then release → SR/EPC reads = 0 and `dout`(sel 15) = 32'h0000_0001. `npc4180` and `if_eret` both stay 0 while `hwint` = 6'h3F.
- Enabled take: `mtc0` SR = 32'h0000_0401 (IM0, IE), then `hwint` = 6'h01 with `cpc` = 32'h0000_3010 → after 2 sync cycles, one `npc4180` pulse. EPC = 32'h0000_3010, SR reads 32'h0000_0403, Cause reads 32'h0000_0400.
- Masked line: SR = 32'h0000_0801, `hwint` = 6'h01 → IP = 1 and `npc4180` never asserts. Setting `hwint` = 6'h02 takes the interrupt.
- Return path: in ISR, `mtc0` EPC = 32'h0000_3020, then `eret` → `if_eret` = 1 for exactly one cycle, `epc` = 32'h0000_3020, SR reads 32'h0000_0401 after the edge. A second `eret` gives `if_eret` = 0.
- Simultaneous events: `mtc0` SR = 0 in the same cycle as a take → write dropped, SR = 32'h0000_0403. Interrupt held during `eret` → a fresh take in the next cycle with EPC = the `cpc` of that cycle.
- Reset mid-ISR: assert `reset` while EXL = 1 → SR = 0 and EPC = 0 before the next edge. `eret` afterward gives `if_eret` = 0.
